dwt_level_sequencer: RTL and testbench

Multi-level scheduler for the DWT lifting datapath. Takes a frame of `FRAME_LEN` samples from upstream over a valid/ready handshake and sequences `NUM_LEVELS` decomposition passes. For each pass it drives the input-mux select, the coarse-FIFO read enable and the lifting-stage valid, and gates whether coarse results are written back. It sits between the sample source and the mux / coarse FIFO / predictor-update pair, and replaces ad-hoc per-level control with one frame-level FSM.

---
 rtl/dwt_level_sequencer_pkg.sv | 18 +
 rtl/dwt_level_sequencer_if.sv | 48 ++++
 rtl/dwt_level_sequencer_len_counter.sv | 37 +++
 rtl/dwt_level_sequencer.sv | 148 ++++++++++++++
 tb/tb_dwt_level_sequencer.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/dwt_level_sequencer_pkg.sv
// Shared types and constants for the DWT level sequencer slice.
package dwt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FEED,
    DRAIN
  } seq_state_t;

  localparam int unsigned DATA_W = 16;

  // Width of the level index; a single-level build still needs one bit.
  function automatic int unsigned lvl_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dwt_level_sequencer_if.sv
// Control bundle between the sample source / coarse FIFO / lifting stage
// and the level sequencer. With DWT_SEQ_STATS_EN defined the bundle also
// carries the FEED stall counter.
interface dwt_level_sequencer_if
  import dwt_pkg::*;
#(
  parameter int unsigned NUM_LEVELS = 3
);

  localparam int unsigned LVL_W = lvl_w(NUM_LEVELS);

  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             coarse_empty;
  logic             data_sel;
  logic             coarse_rd_en;
  logic             lift_valid;
  logic             coarse_keep;
  logic [LVL_W-1:0] level;
  logic             level_done;
  logic             frame_done;
  logic             busy;
`ifdef DWT_SEQ_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  // Environment side: source, FIFO flags and downstream consumers.
  modport master (
`ifdef DWT_SEQ_STATS_EN
    input  stall_cnt,
`endif
    output start, in_valid, coarse_empty,
    input  in_ready, data_sel, coarse_rd_en, lift_valid, coarse_keep,
    input  level, level_done, frame_done, busy
  );

  // Sequencer side.
  modport slave (
`ifdef DWT_SEQ_STATS_EN
    output stall_cnt,
`endif
    input  start, in_valid, coarse_empty,
    output in_ready, data_sel, coarse_rd_en, lift_valid, coarse_keep,
    output level, level_done, frame_done, busy
  );

endinterface

// File: rtl/dwt_level_sequencer_len_counter.sv
// Per-level sample counter: flags the last sample of level k, whose
// length is FRAME_LEN >> k.
module level_len_counter #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned LVL_W     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LVL_W-1:0] level,
  input  logic             inc,
  input  logic             clr,
  output logic             last
);

  localparam int unsigned CNT_W = $clog2(FRAME_LEN) + 1;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;

  // Samples consumed so far in the current level; clear wins over inc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Level length by shift and the last-sample compare.
  always_comb begin
    len  = CNT_W'(FRAME_LEN) >> level;
    last = (cnt == (len - 1'b1));
  end

endmodule

// File: rtl/dwt_level_sequencer.sv
// Frame-level FSM that sequences NUM_LEVELS lifting passes over one frame:
// LOAD from upstream, FEED from the coarse FIFO, DRAIN between levels.
// Optional DWT_SEQ_STATS_EN adds a saturating FEED stall counter.
module dwt_level_sequencer
  import dwt_pkg::*;
#(
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned NUM_LEVELS = 3,
  parameter int unsigned DRAIN_CYC  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  dwt_level_sequencer_if.slave  bus
);

  localparam int unsigned LVL_W    = lvl_w(NUM_LEVELS);
  localparam int unsigned DRN_W    = $clog2(DRAIN_CYC + 1);
  localparam logic [LVL_W-1:0] LAST_LVL = LVL_W'(NUM_LEVELS - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYC - 1);
  localparam bit               DRN_ONE  = (DRAIN_CYC == 1);

  seq_state_t       state;
  logic [LVL_W-1:0] level_q;
  logic [DRN_W-1:0] drain_cnt;
  logic             data_sel_q;
  logic             keep_q;
  logic             level_done_q;
  logic             frame_done_q;
  logic             busy_q;
  logic             rd_q;

  logic             in_load;
  logic             rd_en;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             last_len;
  logic             drain_end;

  // Handshake decode and per-level counter control.
  always_comb begin
    in_load   = (state == LOAD);
    rd_en     = (state == FEED) && !bus.coarse_empty;
    cnt_inc   = (in_load && bus.in_valid) || rd_en;
    drain_end = (state == DRAIN) && (drain_cnt == DRN_LAST);
    cnt_clr   = ((state == IDLE) && bus.start) ||
                (drain_end && (level_q != LAST_LVL));
  end

  level_len_counter #(
    .FRAME_LEN (FRAME_LEN),
    .LVL_W     (LVL_W)
  ) u_len (
    .clk   (clk),
    .rst   (rst),
    .level (level_q),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .last  (last_len)
  );

  // Frame FSM; pulses are registered so they line up with the DRAIN cycle
  // that is about to become the last one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      level_q      <= '0;
      drain_cnt    <= '0;
      data_sel_q   <= 1'b0;
      keep_q       <= 1'b0;
      level_done_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      rd_q         <= 1'b0;
    end else begin
      level_done_q <= 1'b0;
      frame_done_q <= 1'b0;
      rd_q         <= rd_en;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state      <= LOAD;
            level_q    <= '0;
            data_sel_q <= 1'b0;
            keep_q     <= (LAST_LVL != '0);
            busy_q     <= 1'b1;
          end
        end
        LOAD, FEED: begin
          if (cnt_inc && last_len) begin
            state        <= DRAIN;
            drain_cnt    <= '0;
            level_done_q <= DRN_ONE;
            frame_done_q <= DRN_ONE && (level_q == LAST_LVL);
          end
        end
        DRAIN: begin
          if (drain_end) begin
            if (level_q == LAST_LVL) begin
              state      <= IDLE;
              level_q    <= '0;
              data_sel_q <= 1'b0;
              keep_q     <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              state      <= FEED;
              level_q    <= level_q + 1'b1;
              data_sel_q <= 1'b1;
              keep_q     <= ((level_q + 1'b1) != LAST_LVL);
            end
          end else begin
            drain_cnt    <= drain_cnt + 1'b1;
            level_done_q <= ((drain_cnt + 1'b1) == DRN_LAST);
            frame_done_q <= ((drain_cnt + 1'b1) == DRN_LAST) && (level_q == LAST_LVL);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DWT_SEQ_STATS_EN
  logic [15:0] stall_q;

  // Saturating count of FEED cycles spent waiting on an empty coarse FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state == IDLE) && bus.start) begin
      stall_q <= '0;
    end else if ((state == FEED) && bus.coarse_empty && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign bus.stall_cnt = stall_q;
`endif

  assign bus.in_ready     = in_load;
  assign bus.coarse_rd_en = rd_en;
  assign bus.lift_valid   = in_load ? bus.in_valid : rd_q;
  assign bus.data_sel     = data_sel_q;
  assign bus.coarse_keep  = keep_q;
  assign bus.level        = level_q;
  assign bus.level_done   = level_done_q;
  assign bus.frame_done   = frame_done_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_dwt_level_sequencer.sv
// Directed bench for dwt_level_sequencer with FRAME_LEN=8, NUM_LEVELS=3,
// DRAIN_CYC=2. Cycle c is the interval after the c-th rising edge
// following the cycle in which start is driven (cycle 0).
module tb_dwt_level_sequencer;

  localparam int unsigned FL = 8;
  localparam int unsigned NL = 3;
  localparam int unsigned DC = 2;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  dwt_level_sequencer_if #(.NUM_LEVELS(NL)) bus ();

  dwt_level_sequencer #(
    .FRAME_LEN  (FL),
    .NUM_LEVELS (NL),
    .DRAIN_CYC  (DC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // {in_ready, data_sel, coarse_rd_en, lift_valid, level_done, frame_done,
  //  busy, coarse_keep, level[1:0]}
  function automatic logic [15:0] obs();
    return {6'd0, bus.in_ready, bus.data_sel, bus.coarse_rd_en, bus.lift_valid,
            bus.level_done, bus.frame_done, bus.busy, bus.coarse_keep, bus.level};
  endfunction

  function automatic logic [15:0] pack(input bit ir, input bit ds, input bit rd,
                                       input bit lv, input bit ld, input bit fd,
                                       input bit bz, input bit kp, input int lvl);
    logic [1:0] l;
    l = lvl[1:0];
    return {6'd0, ir, ds, rd, lv, ld, fd, bz, kp, l};
  endfunction

  // Hand-derived schedule of an unstalled frame: LOAD 1-8, DRAIN 9-10,
  // FEED 11-14, DRAIN 15-16, FEED 17-18, DRAIN 19-20, IDLE 21.
  function automatic logic [15:0] exp_clean(input int c);
    bit ir, ds, rd, lv, ld, fd, bz, kp;
    int lvl;
    ir  = (c >= 1 && c <= 8);
    ds  = (c >= 11 && c <= 20);
    rd  = (c >= 11 && c <= 14) || (c >= 17 && c <= 18);
    lv  = ir || (c >= 12 && c <= 15) || (c >= 18 && c <= 19);
    ld  = (c == 10) || (c == 16) || (c == 20);
    fd  = (c == 20);
    bz  = (c <= 20);
    kp  = (c <= 16);
    lvl = (c <= 10) ? 0 : (c <= 16) ? 1 : (c <= 20) ? 2 : 0;
    return pack(ir, ds, rd, lv, ld, fd, bz, kp, lvl);
  endfunction

  task automatic chk(input string tag, input int c, input logic [15:0] o,
                     input logic [15:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, c, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full unstalled frame starting in the current (IDLE) cycle; ends in the
  // first IDLE cycle after frame_done with in_valid still high.
  task automatic run_clean(input string tag);
    bus.start        = 1'b1;
    bus.in_valid     = 1'b1;
    bus.coarse_empty = 1'b0;
    for (int c = 1; c <= 21; c++) begin
      step();
      bus.start = 1'b0;
      #1;
      chk(tag, c, obs(), exp_clean(c));
    end
`ifdef DWT_SEQ_STATS_EN
    chk({tag, "_stall"}, 21, bus.stall_cnt, 16'd0);
`endif
  endtask

  initial begin
    int fd_n;
    int fd_c;
    int ld_n;
    errors           = 0;
    checks           = 0;
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.in_valid     = 1'b1;
    bus.coarse_empty = 1'b0;

    // Reset state, with in_valid high to show it is ignored.
    #2;
    chk("reset_t0", 0, obs(), 16'd0);
    step();
    step();
    chk("reset_hold", 0, obs(), 16'd0);
    rst = 1'b0;
    step();
    chk("idle_in_valid", 0, obs(), 16'd0);

    // Clean frame.
    run_clean("clean");
    chk("idle_after_frame", 21, {15'd0, bus.in_ready | bus.lift_valid | bus.busy}, 16'd0);

    // Upstream gap after the 4th sample; start issued in the first IDLE cycle.
    fd_n = 0;
    fd_c = -1;
    bus.start = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      bus.start    = 1'b0;
      bus.in_valid = !(c >= 5 && c <= 7);
      #1;
      if (c <= 12) begin
        chk("gap_ready", c, {15'd0, bus.in_ready}, {15'd0, c <= 11});
        chk("gap_lift", c, {15'd0, bus.lift_valid},
            {15'd0, (c <= 11) && !(c >= 5 && c <= 7)});
      end
      if (c == 7) chk("gap_cnt_hold", c, {12'd0, dut.u_len.cnt}, 16'd4);
      if (bus.frame_done) begin
        fd_n++;
        fd_c = c;
      end
    end
    chk("gap_fd_cycle", 0, fd_c[15:0], 16'd23);
    chk("gap_fd_count", 0, fd_n[15:0], 16'd1);
    chk("gap_idle", 24, {15'd0, bus.busy}, 16'd0);

    // FIFO stall in level-1 FEED plus a start pulse during LOAD.
    fd_n = 0;
    fd_c = -1;
    ld_n = 0;
    bus.start = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      step();
      bus.start        = (c == 3);
      bus.in_valid     = 1'b1;
      bus.coarse_empty = (c >= 12 && c <= 16);
      #1;
      if (c >= 11 && c <= 19)
        chk("stall_rd", c, {15'd0, bus.coarse_rd_en}, {15'd0, !(c >= 12 && c <= 16)});
      if (c == 4) chk("start_ignored", c, {15'd0, bus.in_ready}, 16'd1);
      if (bus.frame_done) begin
        fd_n++;
        fd_c = c;
      end
      if (bus.level_done) ld_n++;
    end
    bus.coarse_empty = 1'b0;
    chk("stall_fd_cycle", 0, fd_c[15:0], 16'd25);
    chk("stall_fd_count", 0, fd_n[15:0], 16'd1);
    chk("stall_ld_count", 0, ld_n[15:0], 16'd3);
    chk("stall_idle", 26, {15'd0, bus.busy}, 16'd0);
`ifdef DWT_SEQ_STATS_EN
    chk("stall_cnt", 26, bus.stall_cnt, 16'd5);
`endif

    // Reset in the middle of level-1 FEED, then a full frame.
    bus.start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      bus.start = 1'b0;
      #1;
      chk("pre_rst", c, obs(), exp_clean(c));
    end
    rst = 1'b1;
    #1;
    chk("rst_async", 12, obs(), 16'd0);
    step();
    chk("rst_idle", 13, obs(), 16'd0);
    rst = 1'b0;
    #1;
    run_clean("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
